// File: rtl/hps_ext_pkg.sv
// Shared constants for the HPS<->core message channel: default opcodes, EXT_BUS bit map,
// reset-notify word and the transaction word counter type.
package hps_ext_pkg;

    localparam logic [15:0] CMD_GET_DEFAULT   = 16'h0034;
    localparam logic [15:0] CMD_SET_DEFAULT   = 16'h0035;

    localparam int          BUS_DOUT_LSB      = 0;
    localparam int          BUS_DIN_LSB       = 16;
    localparam int          BUS_DOUT_EN       = 32;
    localparam int          BUS_STROBE        = 33;
    localparam int          BUS_ENABLE        = 34;

    localparam logic [15:0] RESET_NOTIFY_WORD = 16'h00FF;

    localparam int          BCNT_W            = 10;
    typedef logic [BCNT_W-1:0] bcnt_t;

endpackage

// File: rtl/hps_ext_fifo.sv
// Synchronous show-ahead FIFO: head always presents the oldest entry, level counts entries.
// Pushes into a full queue and pops from an empty queue are dropped.
module hps_ext_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hps_ext_msgq.sv
// HPS<->core message channel on EXT_BUS: core requests are queued and read by GET, SET messages are
// delivered as rx_valid strobes. Optional HPS_EXT_RESET_NOTIFY_EN queues a 16'h00FF event after reset.
module hps_ext_msgq
    import hps_ext_pkg::*;
#(
    parameter logic [15:0] CMD_GET       = CMD_GET_DEFAULT,
    parameter logic [15:0] CMD_SET       = CMD_SET_DEFAULT,
    parameter int          PAYLOAD_WORDS = 3,
    parameter int          QUEUE_DEPTH   = 4,
    localparam int         MSG_W         = 16 * PAYLOAD_WORDS,
    localparam int         LEVEL_W       = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic               clk_sys,
    input  logic               reset,
    inout  wire  [35:0]        EXT_BUS,
    input  logic               tx_valid,
    input  logic [MSG_W-1:0]   tx_data,
    output logic               tx_ready,
    output logic               rx_valid,
    output logic [MSG_W-1:0]   rx_data,
    output logic [LEVEL_W-1:0] tx_level
);

    logic [15:0]      io_din;
    logic             io_strobe;
    logic             io_enable;
    logic [15:0]      io_dout;
    logic             dout_en;
    logic             unused_bus;

    assign io_din     = EXT_BUS[BUS_DIN_LSB +: 16];
    assign io_strobe  = EXT_BUS[BUS_STROBE];
    assign io_enable  = EXT_BUS[BUS_ENABLE];
    assign unused_bus = EXT_BUS[35];
    assign EXT_BUS[BUS_DOUT_LSB +: 16] = io_dout;
    assign EXT_BUS[BUS_DOUT_EN]        = dout_en;

    bcnt_t            byte_cnt;
    logic [15:0]      cmd;
    logic [7:0]       seq;
    logic             armed;
    logic             enable_d;
    logic [MSG_W-1:0] shadow;
    logic [MSG_W-1:0] head;
    logic [MSG_W-1:0] fifo_wdata;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic             notify_push;
    logic             fall;
    logic             msg_done;
    logic             pop;
    logic             deliver;
    logic             seq_inc;
    logic [15:0]      head_word;

`ifdef HPS_EXT_RESET_NOTIFY_EN
    logic notify_pending;
    always_ff @(posedge clk_sys) notify_pending <= reset;
    assign notify_push = notify_pending & ~reset;
`else
    assign notify_push = 1'b0;
`endif

    // The reset-notify push owns the write port in its cycle, so core traffic is held off.
    assign tx_ready   = ~fifo_full & ~notify_push;
    assign fifo_push  = notify_push | (tx_valid & tx_ready);
    assign fifo_wdata = notify_push ? MSG_W'(RESET_NOTIFY_WORD) : tx_data;

    hps_ext_fifo #(
        .W     (MSG_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (fifo_push),
        .wdata   (fifo_wdata),
        .pop     (pop),
        .head    (head),
        .level   (tx_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fall     = enable_d & ~io_enable;
    assign msg_done = byte_cnt > bcnt_t'(PAYLOAD_WORDS);
    assign pop      = fall & (cmd == CMD_GET) & msg_done & armed;
    assign deliver  = fall & (cmd == CMD_SET) & msg_done;
    // A new head is visible when an empty queue gains an entry or a pop leaves one behind.
    assign seq_inc  = (fifo_push & fifo_empty) | (pop & ((tx_level > LEVEL_W'(1)) | fifo_push));

    always_comb begin
        head_word = '0;
        for (int w = 0; w < PAYLOAD_WORDS; w++) begin
            if (byte_cnt == bcnt_t'(w + 1)) head_word = head[w*16 +: 16];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            byte_cnt <= '0;
            cmd      <= '0;
            dout_en  <= 1'b0;
            io_dout  <= '0;
            armed    <= 1'b0;
            shadow   <= '0;
        end else if (!io_enable) begin
            byte_cnt <= '0;
            dout_en  <= 1'b0;
            io_dout  <= '0;
        end else if (io_strobe) begin
            if (byte_cnt != '1) byte_cnt <= byte_cnt + bcnt_t'(1);
            if (byte_cnt == '0) begin
                cmd     <= io_din;
                dout_en <= (io_din >= CMD_GET) && (io_din <= CMD_SET);
                io_dout <= (io_din == CMD_GET) ? {8'(tx_level), seq} : 16'h0000;
                armed   <= 1'b0;
            end else begin
                io_dout <= ((cmd == CMD_GET) && !fifo_empty) ? head_word : 16'h0000;
                // Only a GET that saw real data on its first word may pop at the end.
                if ((cmd == CMD_GET) && (byte_cnt == bcnt_t'(1))) armed <= ~fifo_empty;
                for (int w = 0; w < PAYLOAD_WORDS; w++) begin
                    if ((cmd == CMD_SET) && (byte_cnt == bcnt_t'(w + 1))) shadow[w*16 +: 16] <= io_din;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            enable_d <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            seq      <= '0;
        end else begin
            enable_d <= io_enable;
            rx_valid <= deliver;
            if (deliver) rx_data <= shadow;
            if (seq_inc) seq <= seq + 8'd1;
        end
    end

endmodule

// File: tb/tb_hps_ext_msgq.sv
// Bench for hps_ext_msgq: directed scenarios plus randomized HPS/core traffic against a queue model.
`timescale 1ns/1ps
module tb_hps_ext_msgq;
  localparam int P     = 3;
  localparam int DEPTH = 4;
  localparam int TXW   = 16 * P;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [15:0] CMD_GET = 16'h0034;
  localparam logic [15:0] CMD_SET = 16'h0035;
`ifdef HPS_EXT_RESET_NOTIFY_EN
  localparam bit NOTIFY  = 1'b1;
  localparam int SEQ_OFS = 1;
`else
  localparam bit NOTIFY  = 1'b0;
  localparam int SEQ_OFS = 0;
`endif

  // clock / reset / stimulus signals
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] hps_din = '0;
  logic hps_strobe = 1'b0;
  logic hps_enable = 1'b0;
  logic tx_valid = 1'b0;
  logic [TXW-1:0] tx_data = '0;
  wire tx_ready;
  wire rx_valid;
  wire [TXW-1:0] rx_data;
  wire [LW-1:0] tx_level;
  wire [35:0] ext_bus;

  assign ext_bus[31:16] = hps_din;
  assign ext_bus[33] = hps_strobe;
  assign ext_bus[34] = hps_enable;
  assign ext_bus[35] = 1'b0;

  always #5 clk = ~clk;

  hps_ext_msgq dut (
    .clk_sys(clk), .reset(reset), .EXT_BUS(ext_bus),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_level(tx_level)
  );

  // reference model: message queue with identities, bus transaction bookkeeping
  logic [TXW-1:0] exp_q[$];
  int exp_id[$];
  int next_id = 0;
  logic [7:0] m_seq = '0;
  int m_cnt = 0;
  logic [15:0] m_cmd = '0;
  bit m_den = 0, m_rxv = 0, m_armed = 0, m_en_d = 0, m_npend = 0;
  logic [15:0] m_dout = '0;
  logic [15:0] m_shadow[P];
  logic [15:0] m_rxd[P];

  always @(posedge clk) begin : ref_model
    int old_id, new_id;
    bit fall, do_pop, do_push;
    if (reset) begin
      exp_q.delete(); exp_id.delete();
      m_seq = '0; m_cnt = 0; m_cmd = '0; m_den = 0; m_dout = '0; m_rxv = 0;
      m_armed = 0; m_en_d = 0; m_npend = NOTIFY;
      for (int w = 0; w < P; w++) begin m_shadow[w] = '0; m_rxd[w] = '0; end
    end else begin
      old_id = (exp_q.size() != 0) ? exp_id[0] : -1;
      do_push = tx_valid && (exp_q.size() < DEPTH) && !m_npend;
      fall = m_en_d && !hps_enable;
      do_pop = fall && (m_cmd == CMD_GET) && (m_cnt > P) && m_armed;
      m_rxv = fall && (m_cmd == CMD_SET) && (m_cnt > P);
      if (m_rxv) for (int w = 0; w < P; w++) m_rxd[w] = m_shadow[w];
      if (!hps_enable) begin
        m_den = 0; m_dout = '0; m_cnt = 0;
      end else if (hps_strobe) begin
        if (m_cnt == 0) begin
          m_cmd = hps_din;
          m_den = (hps_din >= CMD_GET) && (hps_din <= CMD_SET);
          m_dout = (hps_din == CMD_GET) ? {8'(exp_q.size()), m_seq} : 16'h0;
          m_armed = 0;
        end else begin
          m_dout = '0;
          if (m_cmd == CMD_GET && m_cnt <= P && exp_q.size() != 0)
            m_dout = 16'(exp_q[0] >> (16 * (m_cnt - 1)));
          if (m_cmd == CMD_GET && m_cnt == 1) m_armed = (exp_q.size() != 0);
          if (m_cmd == CMD_SET && m_cnt <= P) m_shadow[m_cnt-1] = hps_din;
        end
        if (m_cnt < 1023) m_cnt++;
      end
      m_en_d = hps_enable;
      if (do_pop) begin void'(exp_q.pop_front()); void'(exp_id.pop_front()); end
      if (m_npend) begin exp_q.push_back(TXW'(16'h00FF)); exp_id.push_back(next_id++); m_npend = 0; end
      if (do_push) begin exp_q.push_back(tx_data); exp_id.push_back(next_id++); end
      new_id = (exp_q.size() != 0) ? exp_id[0] : -1;
      if (exp_q.size() != 0 && new_id != old_id) m_seq = m_seq + 8'd1;
    end
  end

  // scoreboard
  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 0;
  bit rand_tx = 0;
  logic [15:0] wr_w[16];
  logic [15:0] rd_w[16];
  logic [TXW-1:0] push_val;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [TXW-1:0] exp_rxd;
    bit exp_rdy;
    for (int w = 0; w < P; w++) exp_rxd[w*16 +: 16] = m_rxd[w];
    exp_rdy = (exp_q.size() < DEPTH) && !(m_npend && !reset);
    chk("tx_ready", 64'(tx_ready), 64'(exp_rdy));
    chk("tx_level", 64'(tx_level), 64'(exp_q.size()));
    chk("dout_en", 64'(ext_bus[32]), 64'(m_den));
    chk("io_dout", 64'(ext_bus[15:0]), 64'(m_dout));
    chk("rx_valid", 64'(rx_valid), 64'(m_rxv));
    chk("rx_data", 64'(rx_data), 64'(exp_rxd));
  endtask

  // every cycle: compare on the falling edge, then advance past the rising edge
  task automatic tick();
    @(negedge clk);
    if (chk_on) compare_outputs();
    @(posedge clk);
    #1;
    if (rand_tx) begin
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data = TXW'({$urandom(), $urandom()});
    end
  endtask

  // driver tasks
  task automatic push(input logic [TXW-1:0] v);
    tx_valid = 1'b1; tx_data = v;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic xfer(input int n, input bit push_at_fall, input int rst_at);
    hps_enable = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin reset = 1'b1; tick(); tick(); reset = 1'b0; end
      hps_din = wr_w[i]; hps_strobe = 1'b1;
      tick();
      rd_w[i] = ext_bus[15:0]; hps_strobe = 1'b0;
      repeat ($urandom_range(0, 1)) tick();
    end
    if (rst_at == n) begin reset = 1'b1; tick(); tick(); reset = 1'b0; tick(); end
    hps_enable = 1'b0;
    if (push_at_fall) begin tx_valid = 1'b1; tx_data = push_val; end
    tick();
    if (push_at_fall) tx_valid = 1'b0;
  endtask

  task automatic get_full();
    wr_w[0] = CMD_GET;
    for (int i = 1; i < 16; i++) wr_w[i] = 16'($urandom());
    xfer(P + 1, 1'b0, -1);
  endtask

  logic [TXW-1:0] b[4];

  initial begin
    @(posedge clk); #1;
    chk_on = 1;
    tick(); tick();
    chk("rst_tx_ready", 64'(tx_ready), 64'd1);
    chk("rst_tx_level", 64'(tx_level), 64'd0);
    chk("rst_rx_valid", 64'(rx_valid), 64'd0);
    chk("rst_io_dout", 64'(ext_bus[15:0]), 64'd0);
    chk("rst_dout_en", 64'(ext_bus[32]), 64'd0);
    reset = 1'b0;
    tick();
`ifdef HPS_EXT_RESET_NOTIFY_EN
    get_full();
    chk("notify_word", 64'(rd_w[1]), 64'h00FF);
`endif

    // 1: single message, word order
    push(48'h0001_0002_0003);
    get_full();
    chk("t1_status", 64'(rd_w[0]), 64'({8'd1, 8'(1 + SEQ_OFS)}));
    chk("t1_w1", 64'(rd_w[1]), 64'h0003);
    chk("t1_w2", 64'(rd_w[2]), 64'h0002);
    chk("t1_w3", 64'(rd_w[3]), 64'h0001);
    chk("t1_level", 64'(tx_level), 64'd0);

    // 2: fill, overflow attempt, drain in order
    for (int i = 0; i < 4; i++) begin
      b[i] = {16'hB000 + 16'(i), 16'hC000 + 16'(i), 16'hD000 + 16'(i)};
      push(b[i]);
    end
    chk("t2_full_ready", 64'(tx_ready), 64'd0);
    push(48'hEEEE_EEEE_EEEE);
    chk("t2_full_level", 64'(tx_level), 64'd4);
    for (int i = 0; i < 4; i++) begin
      get_full();
      chk("t2_status", 64'(rd_w[0]), 64'({8'(4 - i), 8'(2 + SEQ_OFS + i)}));
      chk("t2_w1", 64'(rd_w[1]), 64'(16'hD000 + 16'(i)));
      chk("t2_w3", 64'(rd_w[3]), 64'(16'hB000 + 16'(i)));
    end

    // 3: short GET does not pop
    push(48'h0C03_0C02_0C01);
    wr_w[0] = CMD_GET;
    xfer(2, 1'b0, -1);
    chk("t3_short_level", 64'(tx_level), 64'd1);
    get_full();
    chk("t3_reread_w1", 64'(rd_w[1]), 64'h0C01);
    chk("t3_reread_w3", 64'(rd_w[3]), 64'h0C03);

    // 4: SET delivery, short SET discarded
    wr_w[0] = CMD_SET; wr_w[1] = 16'h1111; wr_w[2] = 16'h2222; wr_w[3] = 16'h3333;
    xfer(4, 1'b0, -1);
    chk("t4_rx_valid", 64'(rx_valid), 64'd1);
    chk("t4_rx_data", 64'(rx_data), 64'h3333_2222_1111);
    tick();
    chk("t4_pulse_end", 64'(rx_valid), 64'd0);
    wr_w[0] = CMD_SET; wr_w[1] = 16'h4444;
    xfer(2, 1'b0, -1);
    chk("t4_short_rx_valid", 64'(rx_valid), 64'd0);
    chk("t4_short_rx_data", 64'(rx_data), 64'h3333_2222_1111);

    // 5: unknown opcode, then push and pop in the same cycle
    push(48'h0D03_0D02_0D01);
    wr_w[0] = 16'h0040; wr_w[1] = 16'h0001; wr_w[2] = 16'h0002;
    xfer(3, 1'b0, -1);
    chk("t5_unk_w0", 64'(rd_w[0]), 64'd0);
    chk("t5_unk_w1", 64'(rd_w[1]), 64'd0);
    wr_w[0] = CMD_GET;
    push_val = 48'h0E03_0E02_0E01;
    xfer(P + 1, 1'b1, -1);
    chk("t5_pushpop_w1", 64'(rd_w[1]), 64'h0D01);
    chk("t5_pushpop_level", 64'(tx_level), 64'd1);
    get_full();
    chk("t5_next_w2", 64'(rd_w[2]), 64'h0E02);

    // 6: reset in the middle of a GET
    push(48'h0F03_0F02_0F01);
    wr_w[0] = CMD_GET;
    xfer(2, 1'b0, 2);
    chk("t6_level", 64'(tx_level), 64'(NOTIFY ? 1 : 0));
    chk("t6_rx_valid", 64'(rx_valid), 64'd0);
    chk("t6_io_dout", 64'(ext_bus[15:0]), 64'd0);
`ifdef HPS_EXT_RESET_NOTIFY_EN
    get_full();
    chk("t6_notify_word", 64'(rd_w[1]), 64'h00FF);
`endif

    // randomized traffic
    rand_tx = 1;
    for (int t = 0; t < 160; t++) begin
      int op;
      op = $urandom_range(0, 9);
      for (int i = 0; i < 16; i++) wr_w[i] = 16'($urandom());
      if (op <= 3) begin
        wr_w[0] = CMD_GET; xfer(P + 1 + $urandom_range(0, 1), 1'b0, -1);
      end else if (op == 4) begin
        wr_w[0] = CMD_GET; xfer($urandom_range(1, P), 1'b0, -1);
      end else if (op <= 6) begin
        wr_w[0] = CMD_SET; xfer(P + 1 + $urandom_range(0, 1), 1'b0, -1);
      end else if (op == 7) begin
        wr_w[0] = CMD_SET; xfer($urandom_range(1, P), 1'b0, -1);
      end else if (op == 8) begin
        wr_w[0] = 16'($urandom_range(16'h0036, 16'hFFFF)); xfer($urandom_range(1, P + 1), 1'b0, -1);
      end else if ($urandom_range(0, 3) == 0) begin
        wr_w[0] = CMD_GET; xfer(P + 1, 1'b0, $urandom_range(0, P + 1));
      end else begin
        repeat ($urandom_range(1, 4)) tick();
      end
    end
    rand_tx = 0;
    tx_valid = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
